// File: rtl/rs_encoder_gf32_if.sv
// rtl/rs_encoder_gf32_if.sv - stream handshake bundle for the GF(2^5) RS encoder
//
// Purpose: groups the message input stream and codeword output stream.
// Signals:
//   in_valid/in_ready/in_data           message symbol stream into the encoder
//   out_valid/out_ready/out_data        codeword symbol stream out of the encoder
//   out_sof/out_eof/out_parity          codeword framing markers
// Modports: slave = encoder side, master = source/sink side.
interface rs_encoder_gf32_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic       out_sof;
  logic       out_eof;
  logic       out_parity;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eof, out_parity
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eof, out_parity
  );
endinterface

// File: rtl/rs_encoder_gf32.sv
// rtl/rs_encoder_gf32.sv - systematic RS(K+4,K) encoder over GF(2^5)
//
// Purpose: passes K message symbols through unchanged, then appends the four
// parity symbols p3,p2,p1,p0 of g(x) = x^4 + 30x^3 + 6x^2 + 9x + 17 over the
// field x^5+x^2+1 (alpha = 2). Symbol bit 4 is the MSB; the first message
// symbol is the highest-degree coefficient.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      rs_encoder_gf32_if.slave: input stream (in_*), output stream
//            (out_*) with sof on the first symbol, eof on p0, parity flag
//            on the four parity symbols
// Parameter: K = message symbols per codeword, 1..27 (below 27 = shortened).
module rs_encoder_gf32 #(
  parameter int K = 27
) (
  input  logic               clock,
  input  logic               reset_n,
  rs_encoder_gf32_if.slave   bus
);

  localparam logic [4:0] K_LAST = 5'(K - 1);

  typedef enum logic {ST_MSG, ST_PARITY} state_t;

  state_t     state;
  logic [4:0] count;
  logic [1:0] par_idx;
  logic [4:0] p0, p1, p2, p3;

  logic [4:0] out_data_r;
  logic       out_valid_r;
  logic       out_sof_r;
  logic       out_eof_r;
  logic       out_parity_r;

  logic       advance;
  logic       accept;
  logic [4:0] fb;

  // Multiply in GF(2^5): shift-and-add, reducing x^5 to x^2+1.
  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] acc;
    logic [4:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 5; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x[4] ? ({x[3:0], 1'b0} ^ 5'b00101) : {x[3:0], 1'b0};
    end
    return acc;
  endfunction

  // The single output register may load whenever it is empty or being drained.
  assign advance = !out_valid_r || bus.out_ready;
  assign accept  = (state == ST_MSG) && advance && bus.in_valid;
  assign fb      = bus.in_data ^ p3;

  assign bus.in_ready   = (state == ST_MSG) && advance;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.out_sof    = out_sof_r;
  assign bus.out_eof    = out_eof_r;
  assign bus.out_parity = out_parity_r;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_MSG;
      count        <= 5'd0;
      par_idx      <= 2'd0;
      p0           <= 5'd0;
      p1           <= 5'd0;
      p2           <= 5'd0;
      p3           <= 5'd0;
      out_data_r   <= 5'd0;
      out_valid_r  <= 1'b0;
      out_sof_r    <= 1'b0;
      out_eof_r    <= 1'b0;
      out_parity_r <= 1'b0;
    end else begin
      case (state)
        ST_MSG: begin
          if (accept) begin
            out_data_r   <= bus.in_data;
            out_valid_r  <= 1'b1;
            out_sof_r    <= (count == 5'd0);
            out_eof_r    <= 1'b0;
            out_parity_r <= 1'b0;
            p3 <= p2 ^ gf_mul(5'd30, fb);
            p2 <= p1 ^ gf_mul(5'd6, fb);
            p1 <= p0 ^ gf_mul(5'd9, fb);
            p0 <= gf_mul(5'd17, fb);
            if (count == K_LAST) begin
              state   <= ST_PARITY;
              par_idx <= 2'd0;
              count   <= 5'd0;
            end else begin
              count <= count + 5'd1;
            end
          end else if (advance) begin
            out_valid_r  <= 1'b0;
            out_sof_r    <= 1'b0;
            out_eof_r    <= 1'b0;
            out_parity_r <= 1'b0;
          end
        end
        ST_PARITY: begin
          if (advance) begin
            // Shifting the register out leaves it all-zero after p0, ready
            // for the next codeword.
            out_data_r   <= p3;
            out_valid_r  <= 1'b1;
            out_sof_r    <= 1'b0;
            out_eof_r    <= (par_idx == 2'd3);
            out_parity_r <= 1'b1;
            p3      <= p2;
            p2      <= p1;
            p1      <= p0;
            p0      <= 5'd0;
            par_idx <= par_idx + 2'd1;
            if (par_idx == 2'd3) state <= ST_MSG;
          end
        end
        default: state <= ST_MSG;
      endcase
    end
  end

endmodule
